// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, configuration codes and helpers.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // Number of data bits selected by a cfg_dbits code.
  function automatic logic [3:0] dbits_to_count(input logic [1:0] code);
    case (code)
      DBITS_5: return 4'd5;
      DBITS_6: return 4'd6;
      DBITS_7: return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side request/config bundle of the configurable UART transmitter.
interface uart_tx_cfg_if;
  import uart_pkg::*;

  logic              tx_start;
  logic [DATA_W-1:0] din;
  logic [1:0]        cfg_dbits;
  logic              cfg_par_en;
  logic              cfg_par_odd;
  logic [1:0]        cfg_stop;
  logic              tx_ready;
  logic              tx_done_tick;

  modport master (
    output tx_start, din, cfg_dbits, cfg_par_en, cfg_par_odd, cfg_stop,
    input  tx_ready, tx_done_tick
  );

  modport slave (
    input  tx_start, din, cfg_dbits, cfg_par_en, cfg_par_odd, cfg_stop,
    output tx_ready, tx_done_tick
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter; bit_end_c strobes on the tick that completes a bit.
module uart_bit_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit_m1,
  output logic             bit_end_c
);

  logic [CNT_W-1:0] cnt_q;

  assign bit_end_c = tick && (cnt_q == limit_m1);

  // Count ticks, restarting at each bit boundary or on clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= bit_end_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, optional parity, 1/1.5/2 stop.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned OVS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  uart_tx_cfg_if.slave      host,
  output logic              tx
);

  localparam int unsigned CNT_W = $clog2(2 * OVS);

  uart_state_e       state_q, state_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]        last_q, last_d;
  logic [2:0]        bit_q, bit_d;
  logic              par_q, par_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic [1:0]        stop_q, stop_d;

  logic              accept_c;
  logic              tick_en_c;
  logic              bit_end_c;
  logic [CNT_W-1:0]  limit_m1_c;

  assign accept_c  = ready_q && host.tx_start;
  assign tick_en_c = s_tick && (state_q != ST_IDLE);

  // Bit length in ticks minus one; stop length follows the latched code.
  always_comb begin
    limit_m1_c = CNT_W'(OVS - 1);
    if (state_q == ST_STOP) begin
      case (stop_q)
        STOP_1:   limit_m1_c = CNT_W'(OVS - 1);
        STOP_1P5: limit_m1_c = CNT_W'((3 * OVS) / 2 - 1);
        default:  limit_m1_c = CNT_W'(2 * OVS - 1);
      endcase
    end
  end

  uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept_c),
    .tick      (tick_en_c),
    .limit_m1  (limit_m1_c),
    .bit_end_c (bit_end_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      shreg_q   <= '0;
      last_q    <= '0;
      bit_q     <= '0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop_q    <= STOP_1;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      bit_q     <= bit_d;
      par_q     <= par_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop_q    <= stop_d;
    end
  end

  // Frame sequencing; tx is computed one bit ahead so it changes on the bit-end edge.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    shreg_d   = shreg_q;
    last_d    = last_q;
    bit_d     = bit_q;
    par_d     = par_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop_d    = stop_q;

    case (state_q)
      ST_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (accept_c) begin
          shreg_d   = host.din;
          last_d    = 3'(dbits_to_count(host.cfg_dbits) - 4'd1);
          par_en_d  = host.cfg_par_en;
          par_odd_d = host.cfg_par_odd;
          stop_d    = host.cfg_stop;
          bit_d     = '0;
          par_d     = 1'b0;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          tx_d    = shreg_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          par_d   = par_q ^ shreg_q[0];
          shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
          if (bit_q == last_q) begin
            if (par_en_q) begin
              tx_d    = par_q ^ shreg_q[0] ^ par_odd_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx                = tx_q;
  assign host.tx_ready     = ready_q;
  assign host.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at OVS=16 with s_tick every 4 clocks (64 clocks per bit).
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int unsigned OVS = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] div   = 2'd0;
  logic       s_tick;
  logic       tx;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_cfg_if host ();

  uart_tx_cfg #(.OVS(OVS)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick),
    .host   (host),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) div <= div + 2'd1;
  assign s_tick = (div == 2'd3);

  // Request a frame in a cycle where s_tick is high, so the first counted tick is 4 clocks later.
  task automatic start_frame(input logic [7:0] d, input logic [1:0] db, input logic pe,
                             input logic po, input logic [1:0] st, input bit hold);
    int guard = 0;
    @(negedge clk);
    while (!s_tick && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    host.din         = d;
    host.cfg_dbits   = db;
    host.cfg_par_en  = pe;
    host.cfg_par_odd = po;
    host.cfg_stop    = st;
    host.tx_start    = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) host.tx_start = 1'b0;
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_tx: tx=%b required 0", tx);
    end
    vectors++;
    if (host.tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_ready: tx_ready=%b required 0", host.tx_ready);
    end
  endtask

  // Sample each bit mid-period from accept edge + 1ns, then time the done pulse.
  task automatic check_body(input string name, input logic [11:0] exp_bits, input int n_slots,
                            input int stop_clk, input int phase_adj, input int disturb_slot,
                            input bit hold);
    int waited;
    repeat (32) @(posedge clk);
    #1;
    for (int k = 0; k < n_slots; k++) begin
      if (k > 0) begin
        if (k - 1 == disturb_slot) repeat (63) @(posedge clk);
        else repeat (64) @(posedge clk);
        #1;
      end
      vectors++;
      if (tx !== exp_bits[k]) begin
        miscompares++;
        $display("FAIL %s slot %0d: tx=%b required %b", name, k, tx, exp_bits[k]);
      end
      if (k == disturb_slot) begin
        @(negedge clk);
        host.tx_start    = 1'b1;
        host.din         = 8'h00;
        host.cfg_dbits   = DBITS_5;
        host.cfg_par_en  = ~host.cfg_par_en;
        host.cfg_par_odd = ~host.cfg_par_odd;
        host.cfg_stop    = STOP_1;
        @(negedge clk);
        host.tx_start    = 1'b0;
      end
    end
    vectors++;
    if (host.tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_ready: tx_ready=%b required 0", name, host.tx_ready);
    end
    waited = 0;
    while (waited < 400) begin
      @(posedge clk);
      #1;
      waited++;
      if (host.tx_done_tick === 1'b1) break;
    end
    vectors++;
    if (waited != stop_clk - 32 - phase_adj) begin
      miscompares++;
      $display("FAIL %s done_time: clocks after last stop sample=%0d required %0d",
               name, waited, stop_clk - 32 - phase_adj);
    end
    vectors++;
    if (host.tx_ready !== 1'b1 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL %s end_state: tx_ready=%b tx=%b required 1 1", name, host.tx_ready, tx);
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      vectors++;
      if (host.tx_done_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL %s done_width: tx_done_tick=%b required 0", name, host.tx_done_tick);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (tx !== 1'b1 || host.tx_ready !== 1'b1 || host.tx_done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: tx=%b ready=%b done=%b required 1 1 0",
               tx, host.tx_ready, host.tx_done_tick);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (tx !== 1'b1 || host.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_reset: tx=%b ready=%b required 1 1", tx, host.tx_ready);
    end
  endtask

  task automatic test_8n1();
    start_frame(8'h55, DBITS_8, 1'b0, 1'b0, STOP_1, 1'b0);
    check_body("8n1_55", 12'h2AA, 10, 64, 0, -1, 1'b0);
  endtask

  task automatic test_7e1();
    start_frame(8'h83, DBITS_7, 1'b1, 1'b0, STOP_1, 1'b0);
    check_body("7e1_83", 12'h206, 10, 64, 0, -1, 1'b0);
  endtask

  task automatic test_5o_stops();
    start_frame(8'hFF, DBITS_5, 1'b1, 1'b1, STOP_2, 1'b0);
    check_body("5o2_ff", 12'h0BE, 8, 128, 0, -1, 1'b0);
    start_frame(8'hFF, DBITS_5, 1'b1, 1'b1, STOP_1P5, 1'b0);
    check_body("5o15_ff", 12'h0BE, 8, 96, 0, -1, 1'b0);
  endtask

  task automatic test_busy();
    start_frame(8'h55, DBITS_8, 1'b0, 1'b0, STOP_2, 1'b0);
    check_body("busy_8n2", 12'h2AA, 10, 128, 0, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_frame(8'hA5, DBITS_8, 1'b0, 1'b0, STOP_1, 1'b1);
    check_body("b2b_first", 12'h34A, 10, 64, 0, -1, 1'b1);
    @(posedge clk);
    #1;
    vectors++;
    if (tx !== 1'b0 || host.tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_start: tx=%b ready=%b required 0 0", tx, host.tx_ready);
    end
    host.tx_start = 1'b0;
    check_body("b2b_second", 12'h34A, 10, 64, 1, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    start_frame(8'hA5, DBITS_8, 1'b0, 1'b0, STOP_1, 1'b0);
    repeat (4 * 64 + 32) @(posedge clk);
    #1;
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_bit3: tx=%b required 0", tx);
    end
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1 || host.tx_ready !== 1'b1 || host.tx_done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: tx=%b ready=%b done=%b required 1 1 0",
               tx, host.tx_ready, host.tx_done_tick);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (host.tx_done_tick !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_hold: done=%b tx=%b required 0 1", host.tx_done_tick, tx);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    start_frame(8'hA5, DBITS_8, 1'b0, 1'b0, STOP_1, 1'b0);
    check_body("after_rst_a5", 12'h34A, 10, 64, 0, -1, 1'b0);
  endtask

  initial begin
    host.tx_start    = 1'b0;
    host.din         = 8'h00;
    host.cfg_dbits   = DBITS_8;
    host.cfg_par_en  = 1'b0;
    host.cfg_par_odd = 1'b0;
    host.cfg_stop    = STOP_1;
    test_reset();
    test_8n1();
    test_7e1();
    test_5o_stops();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter that serialises one character per request on `tx` at a baud rate set by an external oversampling tick. It supports 5–8 data bits, optional even/odd parity, and 1, 1.5 or 2 stop bits, all selected per frame. It sits between the transmit FIFO/host interface and the pad, driven by the shared baud-rate generator's `s_tick`.

## Interface
- `OVS`, 16: `s_tick` pulses per bit period; legal range 8–32, must be even so that 1.5 stop bits is exact.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  single-cycle oversampling enable from the baud generator.
- `tx_start`  in  1  frame request; accepted only when `tx_ready`=1.
- `din`  in  8  character; bits above the active data width are ignored.
- `cfg_dbits`  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- `cfg_par_en`  in  1  1 = append a parity bit.
- `cfg_par_odd`  in  1  1 = odd parity, 0 = even parity.
- `cfg_stop`  in  2  stop length: 00=1, 01=1.5, 10=2, 11=reserved (treated as 2).
- `tx`  out  1  serial line, registered; idles high.
- `tx_ready`  out  1  high in IDLE; low from the accept edge until the frame completes.
- `tx_done_tick`  out  1  registered one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **Accept:** on a clock edge with `tx_start`=1 and `tx_ready`=1:
  - latch `din` and all `cfg_*` inputs; later changes to them do not affect the frame in flight;
  - clear the tick counter, the bit counter and the parity accumulator;
  - drive `tx`=0; go to START.
- **START:** lasts OVS `s_tick`s, then go to DATA.
- **DATA:** bits are sent LSB first, each held for OVS ticks.
  - Parity accumulates as the XOR of the transmitted data bits only.
  - After the Nth bit (N = 5..8 from the latched `cfg_dbits`), go to PARITY if parity is enabled, else STOP.
- **PARITY:** `tx` = XOR of the data bits, inverted when odd parity is selected; lasts OVS ticks.
- **STOP:** `tx`=1 for OVS, 3·OVS/2 or 2·OVS ticks. On the final tick:
  - go to IDLE;
  - pulse `tx_done_tick`;
  - assert `tx_ready` on the same edge.
- **Tick counter:** width ⌈log2(2·OVS)⌉, compared against a limit minus 1. It must never wrap inside a bit.
- **`tx_start` while busy:** ignored, not queued. A request held high in the cycle after `tx_done_tick` is accepted, giving back-to-back frames with no idle gap.
- **Reset (including mid-frame):** immediately forces
  - `tx`=1, `tx_ready`=1, `tx_done_tick`=0;
  - state IDLE, all counters 0.
- `s_tick` in the accept cycle is not counted.

## Timing
- `tx` falls on the accept edge, i.e. one clock after `tx_start` is sampled.
- Each bit ends on the edge that samples the bit's final `s_tick`; the next bit's value appears on that same edge.
- **Frame length in ticks:** OVS·(1 + N + P) + stop_ticks, where P = 1 if parity is enabled, else 0.
  - 8N1 at OVS=16: 160 ticks.
  - 7E1.5: 168 ticks.
- `tx_done_tick` is high for exactly one clock, coincident with the first IDLE cycle.
- No combinational path from any input to `tx`.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding enum;
  - `cfg_stop` codes (STOP_1, STOP_1P5, STOP_2);
  - `cfg_dbits` codes;
  - a function mapping `cfg_dbits` to a bit count.
  The matching receiver uses the same package.
- One sub-module: `uart_bit_timer`, a tick counter with a programmable limit and a `bit_end` strobe. It is reused by the receiver.
- Everything else (FSM, shift register, parity accumulator) stays in `uart_tx_cfg`.

## Test plan
- **8N1, `din`=0x55, OVS=16, `s_tick` every 4 clocks:** `tx` = 0,1,0,1,0,1,0,1,0,1, each bit 64 clocks; `tx_done_tick` exactly 640 clocks after the accept edge.
- **7E1, `din`=0x83:** data bits 1,1,0,0,0,0,0; parity bit 0; upper bit of `din` not sent; stop bit 16 ticks.
- **5O2, `din`=0xFF:** five 1s, parity bit 0, stop high for 32 ticks. Repeat with 1.5 stop: stop high for 24 ticks.
- **Busy behaviour:**
  - pulse `tx_start` with `din`=0x00 mid-frame → ignored, current frame unchanged;
  - change `cfg_*` mid-frame → no effect on the frame in flight;
  - hold `tx_start` high → second frame's start bit begins on the edge after `tx_done_tick`.
- **Reset mid-frame:** assert `reset` during DATA bit 3 → `tx`=1 and `tx_ready`=1 asynchronously, no `tx_done_tick`; a fresh 8N1 frame for 0xA5 after release is bit-exact.
